// File: rtl/tone_gen_if.sv
// Control and sample bus between the note controller and the tone generator.
interface tone_gen_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 16
);
    logic          gate;
    logic [1:0]    wave_sel;
    logic [PW-1:0] freq;
    logic [N-1:0]  att_step;
    logic [N-1:0]  rel_step;
    logic [N-1:0]  sample;
    logic          sample_valid;
    logic          active;

    // Controller side: drives note controls, receives samples.
    modport master (
        output gate, wave_sel, freq, att_step, rel_step,
        input  sample, sample_valid, active
    );

    // Generator side.
    modport slave (
        input  gate, wave_sel, freq, att_step, rel_step,
        output sample, sample_valid, active
    );
endinterface

// File: rtl/tone_gen.sv
// Tone generator: one enveloped oscillator sample per 2^N-clock PWM period.
// Pipeline: phase accumulator / LFSR -> gated AR envelope -> wave*env scaling.
// N must match the DAC width, PW must exceed N, and N must not exceed 16.
module tone_gen #(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 16
) (
    input  logic       clk,
    input  logic       reset,
    tone_gen_if.slave  bus
);
    localparam int unsigned LW         = 16;
    localparam int unsigned NW         = 2 * N;
    localparam logic [LW-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [N-1:0]  ENV_MAX   = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ATTACK  = 2'd1;
    localparam logic [1:0] S_SUSTAIN = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [N-1:0]  div_ctr_q, div_ctr_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [LW-1:0] lfsr_q, lfsr_d;
    logic [N-1:0]  env_q, env_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    wsel_q, wsel_d;
    logic          active_q, active_d;
    logic          upd_q, upd_d;
    logic [N-1:0]  sample_q, sample_d;
    logic          sample_valid_q, sample_valid_d;

    logic          tick_c;
    logic          phase_clr_c;
    logic [N:0]    sum_c;
    logic [N:0]    diff_c;
    logic [N-1:0]  p_c;
    logic [N-1:0]  q_c;
    logic [N-1:0]  wave_c;

    assign tick_c = (div_ctr_q == ENV_MAX);

    // Envelope FSM: next state, next envelope level and phase-restart request.
    always_comb begin
        state_d     = state_q;
        env_d       = env_q;
        phase_clr_c = 1'b0;
        sum_c       = {1'b0, env_q} + {1'b0, bus.att_step};
        diff_c      = {1'b0, env_q} - {1'b0, bus.rel_step};
        if (tick_c) begin
            case (state_q)
                S_IDLE: begin
                    env_d = '0;
                    if (bus.gate) begin
                        state_d     = S_ATTACK;
                        phase_clr_c = 1'b1;
                    end
                end
                S_ATTACK: begin
                    if (!bus.gate) begin
                        state_d = S_RELEASE;
                    end else if ((bus.att_step == '0) || sum_c[N] || (sum_c[N-1:0] == ENV_MAX)) begin
                        env_d   = ENV_MAX;
                        state_d = S_SUSTAIN;
                    end else begin
                        env_d = sum_c[N-1:0];
                    end
                end
                S_SUSTAIN: begin
                    env_d = ENV_MAX;
                    if (!bus.gate) begin
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (bus.gate) begin
                        state_d = S_ATTACK;
                    end else if ((bus.rel_step == '0) || diff_c[N] || (diff_c[N-1:0] == '0)) begin
                        env_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        env_d = diff_c[N-1:0];
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Oscillator waveform from the phase snapshot and waveform latched at the last tick.
    always_comb begin
        p_c    = phase_q[PW-1 -: N];
        q_c    = {p_c[N-2:0], 1'b0};
        wave_c = '0;
        case (wsel_q)
            2'b00:   wave_c = p_c[N-1] ? ENV_MAX : '0;
            2'b01:   wave_c = p_c;
            2'b10:   wave_c = p_c[N-1] ? ~q_c : q_c;
            default: wave_c = lfsr_q[LW-1 -: N];
        endcase
    end

    // Tick divider, per-tick oscillator state, and one-cycle-late output scaling.
    always_comb begin
        div_ctr_d      = div_ctr_q + N'(1);
        phase_d        = phase_q;
        lfsr_d         = lfsr_q;
        wsel_d         = wsel_q;
        active_d       = active_q;
        upd_d          = tick_c;
        sample_d       = sample_q;
        sample_valid_d = upd_q;
        if (tick_c) begin
            phase_d  = phase_clr_c ? '0 : (phase_q + bus.freq);
            lfsr_d   = {lfsr_q[LW-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            wsel_d   = bus.wave_sel;
            active_d = (state_d != S_IDLE);
        end
        if (upd_q) begin
            sample_d = N'((NW'(wave_c) * NW'(env_q)) >> N);
        end
    end

    // State registers; reset aborts any note immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_ctr_q      <= '0;
            phase_q        <= '0;
            lfsr_q         <= LFSR_SEED;
            env_q          <= '0;
            state_q        <= S_IDLE;
            wsel_q         <= 2'b00;
            active_q       <= 1'b0;
            upd_q          <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            div_ctr_q      <= div_ctr_d;
            phase_q        <= phase_d;
            lfsr_q         <= lfsr_d;
            env_q          <= env_d;
            state_q        <= state_d;
            wsel_q         <= wsel_d;
            active_q       <= active_d;
            upd_q          <= upd_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.active       = active_q;
endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: stimulus pushes predicted samples, a monitor checks them.
module tb_tone_gen;
    localparam int unsigned N  = 8;
    localparam int unsigned PW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tone_gen_if #(.N(N), .PW(PW)) bus ();
    tone_gen #(.N(N), .PW(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int sample;
        int active;
    } exp_t;

    typedef enum {M_IDLE, M_ATT, M_SUS, M_REL} mst_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vcount   = 0;
    int   cyc      = 0;
    int   last_cyc = -1;
    int   prev_valid = 0;

    mst_t        m_st;
    int          m_env;
    int          m_phase;
    logic [15:0] m_lfsr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_st    = M_IDLE;
        m_env   = 0;
        m_phase = 0;
        m_lfsr  = 16'hACE1;
    endfunction

    // Reference: one PWM period of the note, returns the scaled sample for this tick.
    function automatic int model_step(input int g, input int ws, input int fr, input int at, input int rl);
        int p, w;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (m_st == M_IDLE && g != 0) m_phase = 0;
        else                          m_phase = (m_phase + fr) % 65536;
        case (m_st)
            M_IDLE: begin
                m_env = 0;
                if (g != 0) m_st = M_ATT;
            end
            M_ATT: begin
                if (g == 0) m_st = M_REL;
                else begin
                    m_env = (at == 0 || m_env + at > 255) ? 255 : m_env + at;
                    if (m_env == 255) m_st = M_SUS;
                end
            end
            M_SUS: begin
                m_env = 255;
                if (g == 0) m_st = M_REL;
            end
            M_REL: begin
                if (g != 0) m_st = M_ATT;
                else begin
                    m_env = (rl == 0 || m_env - rl < 0) ? 0 : m_env - rl;
                    if (m_env == 0) m_st = M_IDLE;
                end
            end
        endcase
        p = m_phase / 256;
        case (ws)
            0:       w = (p >= 128) ? 255 : 0;
            1:       w = p;
            2:       w = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            default: w = int'(m_lfsr) / 256;
        endcase
        return (w * m_env) / 256;
    endfunction

    // Monitor: pop and compare on every sample_valid pulse, plus pulse timing.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            last_cyc   = -1;
            prev_valid = 0;
        end else begin
            if (bus.sample_valid) begin
                check("valid_one_cycle", prev_valid, 0);
                if (last_cyc >= 0) check("valid_spacing", cyc - last_cyc, 256);
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", int'(bus.sample), e.sample);
                    check("active", int'(bus.active), e.active);
                end
                vcount++;
            end
            prev_valid = int'(bus.sample_valid);
        end
    end

    task automatic set_inputs(input int g, input int ws, input int fr, input int at, input int rl);
        bus.gate     = 1'(g);
        bus.wave_sel = 2'(ws);
        bus.freq     = 16'(fr);
        bus.att_step = 8'(at);
        bus.rel_step = 8'(rl);
    endtask

    // One tick: apply controls, predict (or use a fixed expectation), wait for the pulse.
    task automatic do_tick(input int g, input int ws, input int fr, input int at, input int rl, input int lit);
        exp_t e;
        int   start;
        int   n;
        set_inputs(g, ws, fr, at, rl);
        e.sample = model_step(g, ws, fr, at, rl);
        if (lit >= 0) e.sample = lit;
        e.active = (m_st != M_IDLE) ? 1 : 0;
        exp_q.push_back(e);
        start = vcount;
        n     = 0;
        while (vcount == start && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (vcount == start) check("valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        int g, ws, fr, at, rl, n, dummy;
        set_inputs(0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sample", int'(bus.sample), 0);
        check("rst_valid", int'(bus.sample_valid), 0);
        check("rst_active", int'(bus.active), 0);
        reset = 1'b1;

        // Reach sample=200 (env 201 on a high square), then reset mid-cycle.
        do_tick(1, 0, 16'h8000, 201, 0, 0);
        set_inputs(1, 0, 16'h8000, 201, 0);
        dummy = model_step(1, 0, 16'h8000, 201, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.sample_valid && n < 600);
        check("pre_reset_valid", int'(bus.sample_valid), 1);
        check("pre_reset_sample", int'(bus.sample), 200);
        #1 reset = 1'b0;
        #1;
        check("async_rst_sample", int'(bus.sample), 0);
        check("async_rst_valid", int'(bus.sample_valid), 0);
        check("async_rst_active", int'(bus.active), 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        model_reset();
        reset = 1'b1;

        // Square at half-scale frequency, instant attack.
        do_tick(1, 0, 16'h8000, 0, 0, 0);
        do_tick(1, 0, 16'h8000, 0, 0, 254);
        do_tick(1, 0, 16'h8000, 0, 0, 0);
        do_tick(1, 0, 16'h8000, 0, 0, 254);
        do_tick(0, 0, 16'h8000, 0, 0, -1);
        do_tick(0, 0, 16'h8000, 0, 0, -1);

        // Attack ramp, release, retrigger from env=55, release to idle (square held high).
        do_tick(1, 0, 16'hFF00, 64, 100, 0);
        do_tick(1, 0, 16'hFF00, 64, 100, 63);
        do_tick(1, 0, 16'hFF00, 64, 100, 127);
        do_tick(1, 0, 16'hFF00, 64, 100, 191);
        do_tick(1, 0, 16'hFF00, 64, 100, 254);
        do_tick(0, 0, 16'hFF00, 64, 100, 254);
        do_tick(0, 0, 16'hFF00, 64, 100, 154);
        do_tick(0, 0, 16'hFF00, 64, 100, 54);
        do_tick(1, 0, 16'hFF00, 100, 100, 54);
        do_tick(1, 0, 16'hFF00, 100, 100, 154);
        do_tick(1, 0, 16'hFF00, 100, 100, 254);
        do_tick(0, 0, 16'hFF00, 100, 100, 254);
        do_tick(0, 0, 16'hFF00, 100, 100, 154);
        do_tick(0, 0, 16'hFF00, 100, 100, 54);
        do_tick(0, 0, 16'hFF00, 100, 100, 0);

        // Noise from a fresh LFSR: second value 0xB387 -> (179*255)>>8.
        do_reset();
        do_tick(1, 3, 0, 0, 0, 0);
        do_tick(1, 3, 0, 0, 0, 178);

        // Randomised notes against the reference model.
        g = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0) g = 1 - g;
            ws = int'($urandom_range(0, 3));
            fr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535));
            at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            rl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            do_tick(g, ws, fr, at, rl, -1);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
